// File: rtl/pointwise_conv_engine.sv
// rtl/pointwise_conv_engine.sv - 1x1 convolution engine with DSP_NO parallel MAC lanes and group time-multiplexing
module pointwise_conv_engine #(
    parameter int WIDTH  = 16,
    parameter int FRAC   = 8,
    parameter int CHIN   = 512,
    parameter int CHOUT  = 64,
    parameter int DSP_NO = 16,
    parameter int PIXELS = 256,
    parameter int ACC_W  = 2*WIDTH + $clog2(CHIN),
    localparam int G     = CHOUT / DSP_NO,
    localparam int WAW   = (CHIN*G > 1) ? $clog2(CHIN*G) : 1,
    localparam int GW    = (G > 1) ? $clog2(G) : 1,
    localparam int PW    = (PIXELS > 1) ? $clog2(PIXELS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     relu_en,
    output logic                     busy,
    output logic                     done,
    input  logic [WIDTH-1:0]         ifm,
    input  logic                     ifm_valid,
    output logic                     ifm_ready,
    output logic [WAW-1:0]           weight_addr,
    input  logic [DSP_NO*WIDTH-1:0]  weight_data,
    output logic [GW-1:0]            bias_addr,
    input  logic [DSP_NO*WIDTH-1:0]  bias_data,
    output logic [DSP_NO*WIDTH-1:0]  ofm,
    output logic                     ofm_valid,
    input  logic                     ofm_ready,
    output logic [PW-1:0]            ofm_pixel,
    output logic [GW-1:0]            ofm_group
);

    localparam int CW    = (CHIN > 1) ? $clog2(CHIN) : 1;
    localparam int SUM_W = ACC_W + 1;
    localparam logic signed [SUM_W-1:0] MAX_V = SUM_W'((1 <<< (WIDTH-1)) - 1);
    localparam logic signed [SUM_W-1:0] MIN_V = ~MAX_V;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state, state_nx;

    logic [CW-1:0] ch;
    logic [GW-1:0] group;
    logic [PW-1:0] pixel;
    logic          relu_q;
    logic          en, beat, last_ch, last_grp, last_pix, last_beat, final_hs;

    logic                    s1_valid, s1_first, s1_last;
    logic signed [WIDTH-1:0] s1_ifm;
    logic signed [WIDTH-1:0] s1_w [DSP_NO];
    logic signed [WIDTH-1:0] s1_b [DSP_NO];
    logic [PW-1:0]           s1_pix;
    logic [GW-1:0]           s1_grp;

    logic                    s2_last;
    logic signed [ACC_W-1:0] acc [DSP_NO];
    logic signed [ACC_W-1:0] acc_nx [DSP_NO];
    logic signed [2*WIDTH-1:0] prod [DSP_NO];
    logic signed [WIDTH-1:0] s2_b [DSP_NO];
    logic [PW-1:0]           s2_pix;
    logic [GW-1:0]           s2_grp;

    // A held result blocks every stage so no in-flight beat is lost.
    assign en        = !(ofm_valid && !ofm_ready);
    assign ifm_ready = (state == RUN) && en;
    assign beat      = ifm_valid && ifm_ready;
    assign busy      = (state != IDLE);

    assign last_ch   = (ch == CW'(CHIN-1));
    assign last_grp  = (group == GW'(G-1));
    assign last_pix  = (pixel == PW'(PIXELS-1));
    assign last_beat = last_ch && last_grp && last_pix;
    assign final_hs  = (state == DRAIN) && ofm_valid && ofm_ready &&
                       (ofm_pixel == PW'(PIXELS-1)) && (ofm_group == GW'(G-1));

    assign weight_addr = WAW'(int'(group) * CHIN + int'(ch));
    assign bias_addr   = group;

    function automatic logic [WIDTH-1:0] post_proc(input logic signed [ACC_W-1:0] a,
                                                   input logic signed [WIDTH-1:0] b,
                                                   input logic                    relu);
        logic signed [SUM_W-1:0] s;
        s = (SUM_W'(a) + (SUM_W'(b) <<< FRAC)) >>> FRAC;
        if (relu && s[SUM_W-1])
            s = '0;
        if (s > MAX_V)
            return MAX_V[WIDTH-1:0];
        else if (s < MIN_V)
            return MIN_V[WIDTH-1:0];
        return s[WIDTH-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (beat && last_beat) state_nx = DRAIN;
            DRAIN:   if (final_hs) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ch     <= '0;
            group  <= '0;
            pixel  <= '0;
            relu_q <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= final_hs;
            if (state == IDLE && start) begin
                ch     <= '0;
                group  <= '0;
                pixel  <= '0;
                relu_q <= relu_en;
            end else if (beat) begin
                ch <= last_ch ? '0 : ch + 1'b1;
                if (last_ch) begin
                    group <= last_grp ? '0 : group + 1'b1;
                    if (last_grp)
                        pixel <= last_pix ? '0 : pixel + 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DSP_NO; i++) begin
            prod[i]   = s1_ifm * s1_w[i];
            acc_nx[i] = (s1_first ? '0 : acc[i]) + ACC_W'(prod[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_ifm   <= '0;
            s1_pix   <= '0;
            s1_grp   <= '0;
            s2_last  <= 1'b0;
            s2_pix   <= '0;
            s2_grp   <= '0;
            for (int i = 0; i < DSP_NO; i++) begin
                s1_w[i] <= '0;
                s1_b[i] <= '0;
                s2_b[i] <= '0;
                acc[i]  <= '0;
            end
        end else if (en) begin
            s1_valid <= beat;
            if (beat) begin
                s1_ifm   <= ifm;
                s1_first <= (ch == '0);
                s1_last  <= last_ch;
                s1_pix   <= pixel;
                s1_grp   <= group;
                for (int i = 0; i < DSP_NO; i++) begin
                    s1_w[i] <= weight_data[i*WIDTH +: WIDTH];
                    if (last_ch)
                        s1_b[i] <= bias_data[i*WIDTH +: WIDTH];
                end
            end
            s2_last <= s1_valid && s1_last;
            if (s1_valid) begin
                for (int i = 0; i < DSP_NO; i++)
                    acc[i] <= acc_nx[i];
            end
            // Bias and indices travel with the closing beat so the next group cannot overwrite them.
            if (s1_valid && s1_last) begin
                s2_pix <= s1_pix;
                s2_grp <= s1_grp;
                for (int i = 0; i < DSP_NO; i++)
                    s2_b[i] <= s1_b[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ofm       <= '0;
            ofm_valid <= 1'b0;
            ofm_pixel <= '0;
            ofm_group <= '0;
        end else if (en && s2_last) begin
            for (int i = 0; i < DSP_NO; i++)
                ofm[i*WIDTH +: WIDTH] <= post_proc(acc[i], s2_b[i], relu_q);
            ofm_pixel <= s2_pix;
            ofm_group <= s2_grp;
            ofm_valid <= 1'b1;
        end else if (ofm_ready) begin
            ofm_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pointwise_conv_engine.sv
// tb/tb_pointwise_conv_engine.sv - directed self-checking bench for pointwise_conv_engine
module tb_pointwise_conv_engine;

    logic        clk = 1'b0;
    logic        rst, start, relu_en, busy, done;
    logic [15:0] ifm;
    logic        ifm_valid, ifm_ready;
    logic [2:0]  weight_addr;
    logic [63:0] weight_data, bias_data, ofm;
    logic        bias_addr, ofm_valid, ofm_ready, ofm_pixel, ofm_group;

    logic [15:0] wval, ifm_const;
    logic [15:0] bias_lane [4];
    logic [15:0] lane_exp [4];
    logic [63:0] r_ofm [4];
    int          r_pix [4];
    int          r_grp [4];
    int          mode, total, bad, done_cnt, d0;

    always #5 clk = ~clk;

    assign weight_data = {4{wval}};
    assign bias_data   = {bias_lane[3], bias_lane[2], bias_lane[1], bias_lane[0]};

    pointwise_conv_engine #(
        .WIDTH(16), .FRAC(8), .CHIN(4), .CHOUT(8), .DSP_NO(4), .PIXELS(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .relu_en(relu_en),
        .busy(busy), .done(done),
        .ifm(ifm), .ifm_valid(ifm_valid), .ifm_ready(ifm_ready),
        .weight_addr(weight_addr), .weight_data(weight_data),
        .bias_addr(bias_addr), .bias_data(bias_data),
        .ofm(ofm), .ofm_valid(ofm_valid), .ofm_ready(ofm_ready),
        .ofm_pixel(ofm_pixel), .ofm_group(ofm_group)
    );

    initial done_cnt = 0;
    always @(negedge clk) if (done === 1'b1) done_cnt = done_cnt + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic feed(input int nbeats);
        int j = 0;
        int cyc = 0;
        bit acc;
        while (j < nbeats && cyc < 500) begin
            ifm_valid = 1'b1;
            ifm = (mode == 1) ? 16'((j % 4 + 1) * 256) : ifm_const;
            @(negedge clk);
            acc = ifm_ready;
            if (acc) begin
                chk("weight_addr", 64'(weight_addr), 64'(((j / 4) % 2) * 4 + j % 4));
                chk("bias_addr", 64'(bias_addr), 64'((j / 4) % 2));
            end
            @(posedge clk); #1;
            if (acc) j++;
            cyc++;
        end
        ifm_valid = 1'b0;
        if (j < nbeats) chk("feed_timeout", 64'(j), 64'(nbeats));
    endtask

    task automatic collect(input int n, input bit stall);
        int got = 0;
        int cyc = 0;
        int sc = 0;
        logic [63:0] snap = '0;
        ofm_ready = !stall;
        while (got < n && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (ofm_valid && ofm_ready) begin
                r_ofm[got] = ofm;
                r_pix[got] = int'(ofm_pixel);
                r_grp[got] = int'(ofm_group);
                got++;
            end else if (ofm_valid && stall && sc < 10) begin
                if (sc == 0) snap = ofm;
                else chk("stall_ofm_stable", ofm, snap);
                chk("stall_ifm_ready", 64'(ifm_ready), 64'(0));
                sc++;
            end
            @(posedge clk); #1;
            if (sc >= 10) ofm_ready = 1'b1;
        end
        if (got < n) chk("collect_timeout", 64'(got), 64'(n));
    endtask

    task automatic run_layer(input bit relu, input bit stall);
        relu_en = relu;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        relu_en = 1'b0;
        chk("busy_rise", 64'(busy), 64'(1));
        fork
            feed(16);
            collect(4, stall);
        join
        @(negedge clk);
        chk("done_high", 64'(done), 64'(1));
        chk("busy_fall", 64'(busy), 64'(0));
        @(negedge clk);
        chk("done_pulse", 64'(done), 64'(0));
    endtask

    task automatic check_results(input string tag);
        for (int k = 0; k < 4; k++) begin
            chk({tag, "_pixel"}, 64'(r_pix[k]), 64'(k / 2));
            chk({tag, "_group"}, 64'(r_grp[k]), 64'(k % 2));
            for (int i = 0; i < 4; i++)
                chk({tag, "_lane"}, 64'(r_ofm[k][i*16 +: 16]), 64'(lane_exp[i]));
        end
    endtask

    task automatic set_exp(input logic [15:0] v);
        for (int i = 0; i < 4; i++) lane_exp[i] = v;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
        chk({tag, "_ifm_ready"}, 64'(ifm_ready), 64'(0));
        chk({tag, "_ofm_valid"}, 64'(ofm_valid), 64'(0));
        chk({tag, "_ofm"}, ofm, 64'(0));
        chk({tag, "_ofm_pixel"}, 64'(ofm_pixel), 64'(0));
        chk({tag, "_ofm_group"}, 64'(ofm_group), 64'(0));
        chk({tag, "_weight_addr"}, 64'(weight_addr), 64'(0));
        chk({tag, "_bias_addr"}, 64'(bias_addr), 64'(0));
    endtask

    initial begin
        total = 0; bad = 0; mode = 0;
        rst = 1'b0; start = 1'b0; relu_en = 1'b0;
        ifm_valid = 1'b0; ofm_ready = 1'b0; ifm = '0;
        wval = '0; ifm_const = '0;
        for (int i = 0; i < 4; i++) bias_lane[i] = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        ifm_const = 16'h0100; wval = 16'h0080; set_exp(16'h0200);
        run_layer(1'b0, 1'b0);
        check_results("basic");

        ifm_const = 16'hFF00; wval = 16'h0100; set_exp(16'h0000);
        run_layer(1'b1, 1'b0);
        check_results("neg_relu");
        set_exp(16'hFC00);
        run_layer(1'b0, 1'b0);
        check_results("neg_norelu");

        ifm_const = 16'h7FFF; wval = 16'h7FFF; set_exp(16'h7FFF);
        run_layer(1'b0, 1'b0);
        check_results("sat_pos");
        wval = 16'h8001; set_exp(16'h8000);
        run_layer(1'b0, 1'b0);
        check_results("sat_neg");

        mode = 1; wval = 16'h0080; set_exp(16'h0500);
        run_layer(1'b0, 1'b0);
        check_results("ramp_nostall");
        run_layer(1'b0, 1'b1);
        check_results("ramp_stall");
        mode = 0;

        ifm_const = 16'h0000; wval = 16'h1234;
        for (int i = 0; i < 4; i++) begin
            bias_lane[i] = 16'(i * 256);
            lane_exp[i]  = 16'(i * 256);
        end
        run_layer(1'b0, 1'b0);
        check_results("bias");
        for (int i = 0; i < 4; i++) bias_lane[i] = '0;

        d0 = done_cnt;
        ifm_const = 16'h0100; wval = 16'h0080; set_exp(16'h0200);
        ofm_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        feed(6);
        rst = 1'b0;
        #1;
        check_reset_values("midrun_reset");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        run_layer(1'b0, 1'b0);
        check_results("after_reset");
        chk("single_done", 64'(done_cnt - d0), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
